mem_access: RTL

Memory-access stage of the core, sitting directly downstream of the execute stage. It accepts an executed instruction (decoded instruction bundle, register-operand pair and the ALU result), performs the RV32I load or store it describes on a word-wide memory bus with a valid/ready handshake, and returns the write-back value together with a one-cycle `completed` pulse. Non-memory instructions pass through with fixed one-cycle latency.

---
 rtl/mem_access.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_access.sv
// Memory-access stage: RV32I loads/stores over a word bus
// with valid/ready handshake; other instructions pass through.
package mem_access_pkg;

   typedef struct packed {
      logic lb, lh, lw, lbu, lhu;
      logic sb, sh, sw;
      logic alu;
   } instructions;

   typedef struct packed {
      logic [31:0] rs1;
      logic [31:0] rs2;
   } regvpair;

endpackage

module mem_access
   import mem_access_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enabled,
   output logic        completed,
   input  instructions instr,
   input  regvpair     register,
   input  logic [31:0] exec_result,
   output instructions instr_n,
   output regvpair     register_n,
   output logic [31:0] result,
   output logic        misaligned,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t      state_q;
   logic [31:0] a_q;
   logic        completed_q;
   instructions instr_n_q;
   regvpair     register_n_q;
   logic [31:0] result_q;
   logic        misaligned_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;
   logic [3:0]  mem_wstrb_q;

   logic [1:0]  off_d;
   logic        ld_d;
   logic        st_d;
   logic        mis_d;
   logic [31:0] wdata_d;
   logic [3:0]  wstrb_d;
   logic [31:0] lane_d;
   logic [31:0] ld_val_d;

   assign off_d = exec_result[1:0];
   assign ld_d  = instr.lb | instr.lh | instr.lw
                | instr.lbu | instr.lhu;
   assign st_d  = instr.sb | instr.sh | instr.sw;
   assign mis_d = ((instr.lh | instr.lhu | instr.sh) & off_d[0])
                | ((instr.lw | instr.sw) & (off_d != 2'b00));

   always_comb begin
      wdata_d = '0;
      wstrb_d = '0;
      unique case (1'b1)
         instr.sb: begin
            wdata_d = {4{register.rs2[7:0]}};
            wstrb_d = 4'b0001 << off_d;
         end
         instr.sh: begin
            wdata_d = {2{register.rs2[15:0]}};
            wstrb_d = 4'b0011 << {off_d[1], 1'b0};
         end
         instr.sw: begin
            wdata_d = register.rs2;
            wstrb_d = 4'b1111;
         end
         default: ;
      endcase
   end

   // Only aligned accesses reach ACCESS, so one shift serves all widths.
   assign lane_d = mem_rdata >> {a_q[1:0], 3'b000};

   always_comb begin
      ld_val_d = lane_d;
      unique case (1'b1)
         instr_n_q.lb:  ld_val_d = {{24{lane_d[7]}}, lane_d[7:0]};
         instr_n_q.lbu: ld_val_d = {24'b0, lane_d[7:0]};
         instr_n_q.lh:  ld_val_d = {{16{lane_d[15]}}, lane_d[15:0]};
         instr_n_q.lhu: ld_val_d = {16'b0, lane_d[15:0]};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         a_q          <= '0;
         completed_q  <= 1'b0;
         instr_n_q    <= '0;
         register_n_q <= '0;
         result_q     <= '0;
         misaligned_q <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
      end else begin
         completed_q <= 1'b0;
         unique case (state_q)
            IDLE: if (enabled) begin
               instr_n_q    <= instr;
               register_n_q <= register;
               a_q          <= exec_result;
               misaligned_q <= mis_d;
               if ((ld_d | st_d) && !mis_d) begin
                  state_q     <= ACCESS;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= st_d;
                  mem_addr_q  <= {exec_result[31:2], 2'b00};
                  mem_wdata_q <= wdata_d;
                  mem_wstrb_q <= wstrb_d;
               end else begin
                  state_q <= DONE;
               end
            end
            ACCESS: if (mem_ready) begin
               state_q     <= IDLE;
               mem_req_q   <= 1'b0;
               mem_we_q    <= 1'b0;
               mem_wstrb_q <= '0;
               completed_q <= 1'b1;
               result_q    <= mem_we_q ? a_q : ld_val_d;
            end
            DONE: begin
               state_q     <= IDLE;
               completed_q <= 1'b1;
               result_q    <= a_q;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign completed  = completed_q;
   assign instr_n    = instr_n_q;
   assign register_n = register_n_q;
   assign result     = result_q;
   assign misaligned = misaligned_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wstrb  = mem_wstrb_q;

endmodule
